// File: rtl/e_mdu_iter_pkg.sv
// e_mdu_iter_pkg: shared definitions for the E-stage multiply/divide unit.
//   MDU_* op codes are shared with the decoder and the hazard unit.
//   mdu_state_e is the MDU sequencing FSM encoding.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu codes).
package e_mdu_iter_pkg;

  localparam logic [3:0] MDU_NOP   = 4'h0;
  localparam logic [3:0] MDU_MULT  = 4'h1;
  localparam logic [3:0] MDU_MULTU = 4'h2;
  localparam logic [3:0] MDU_DIV   = 4'h3;
  localparam logic [3:0] MDU_DIVU  = 4'h4;
  localparam logic [3:0] MDU_MTHI  = 4'h5;
  localparam logic [3:0] MDU_MTLO  = 4'h6;
  localparam logic [3:0] MDU_MFHI  = 4'h7;
  localparam logic [3:0] MDU_MFLO  = 4'h8;
  localparam logic [3:0] MDU_MADD  = 4'h9;
  localparam logic [3:0] MDU_MADDU = 4'hA;
  localparam logic [3:0] MDU_MSUB  = 4'hB;
  localparam logic [3:0] MDU_MSUBU = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/e_mdu_iter_div_core.sv
// e_mdu_div_core: unsigned WIDTH-bit restoring divider, one quotient bit per cycle.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : capture dividend/divisor and start WIDTH iterations
//   dividend   : unsigned dividend
//   divisor    : unsigned divisor (zero gives quo=all-ones, rem=dividend)
//   done       : no iteration pending; quo/rem hold the last result
//   quo, rem   : quotient and remainder
module e_mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Quotient register doubles as the dividend shift register: its MSB feeds
  // the partial remainder while quotient bits enter at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/e_mdu_iter.sv
// e_mdu_iter: E-stage multiply/divide unit with HI/LO registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : E-stage MDU instruction valid (ignored while busy)
//   mdu_op     : MDU_* op code
//   A, B       : rs / rt operands
//   busy       : multi-cycle operation in flight
//   hi, lo     : HI/LO registers
// Multiply: MUL_CYCLES busy cycles. Divide: WIDTH iterations plus one sign-fix cycle.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu;
// without it those codes are no-ops.
module e_mdu_iter
  import e_mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               mul_sgn_q, mul_sgn_d;
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               acc_en_q, acc_en_d;
  logic               acc_sub_q, acc_sub_d;
`endif

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  logic               div_load, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  // Only signed divide strips signs; divu passes operands through.
  assign a_neg = (mdu_op == MDU_DIV) & A[WIDTH-1];
  assign b_neg = (mdu_op == MDU_DIV) & B[WIDTH-1];
  assign a_abs = a_neg ? -A : A;
  assign b_abs = b_neg ? -B : B;

  assign ext_a = mul_sgn_q ? {{WIDTH{op_a_q[WIDTH-1]}}, op_a_q} : {{WIDTH{1'b0}}, op_a_q};
  assign ext_b = mul_sgn_q ? {{WIDTH{op_b_q[WIDTH-1]}}, op_b_q} : {{WIDTH{1'b0}}, op_b_q};
  assign prod  = ext_a * ext_b;

`ifdef MDU_MADD_EN
  assign mul_res = !acc_en_q ? prod : (acc_sub_q ? acc_q - prod : acc_q + prod);
`else
  assign mul_res = prod;
`endif

  e_mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .dividend (a_abs),
    .divisor  (b_abs),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mul_sgn_d = mul_sgn_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_load  = 1'b0;
`ifdef MDU_MADD_EN
    acc_d     = acc_q;
    acc_en_d  = acc_en_q;
    acc_sub_d = acc_sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdu_op)
            MDU_MULT, MDU_MULTU: begin
              state_d   = S_MUL;
              cnt_d     = CNT_W'(MUL_CYCLES - 1);
              op_a_d    = A;
              op_b_d    = B;
              mul_sgn_d = (mdu_op == MDU_MULT);
`ifdef MDU_MADD_EN
              acc_en_d  = 1'b0;
`endif
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
              state_d   = S_MUL;
              cnt_d     = CNT_W'(MUL_CYCLES - 1);
              op_a_d    = A;
              op_b_d    = B;
              mul_sgn_d = (mdu_op == MDU_MADD) || (mdu_op == MDU_MSUB);
              acc_en_d  = 1'b1;
              acc_sub_d = (mdu_op == MDU_MSUB) || (mdu_op == MDU_MSUBU);
              acc_d     = {hi_q, lo_q};
            end
`endif
            MDU_DIV, MDU_DIVU: begin
              state_d   = S_DIV;
              cnt_d     = CNT_W'(WIDTH - 1);
              op_a_d    = a_abs;
              op_b_d    = b_abs;
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              div_load  = 1'b1;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        // Divide by zero forces an all-ones quotient regardless of sign;
        // MIN/-1 needs no special case since -(2^(W-1)) wraps back to MIN.
        if (div_done) begin
          lo_d    = (op_b_q == '0) ? '1 : (quo_neg_q ? -div_quo : div_quo);
          hi_d    = rem_neg_q ? -div_rem : div_rem;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      mul_sgn_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MDU_MADD_EN
      acc_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      mul_sgn_q <= mul_sgn_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MDU_MADD_EN
      acc_q     <= acc_d;
      acc_en_q  <= acc_en_d;
      acc_sub_q <= acc_sub_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
